// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: datapath width,
// RV64I load funct3 encodings and the retired-counter reset value.
package wb_stage_pkg;

  localparam int XLEN      = 64;
  localparam int INSTRET_W = 64;

  localparam logic [INSTRET_W-1:0] INSTRET_RST = '0;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load formatter: picks the naturally aligned lane and sign/zero extends.
// Ports: funct3_i, addr_lo_i, data_i (raw doubleword) -> data_o.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  logic [2:0]      off;
  logic [XLEN-1:0] lane;

  // Low offset bits are dropped so the lane is always naturally aligned.
  always_comb begin
    off = 3'd0;
    unique case (funct3_i)
      LB, LBU: off = addr_lo_i;
      LH, LHU: off = {addr_lo_i[2:1], 1'b0};
      LW, LWU: off = {addr_lo_i[2], 2'b00};
      default: off = 3'd0;
    endcase
  end

  assign lane = data_i >> {off, 3'b000};

  always_comb begin
    data_o = '0;
    unique case (funct3_i)
      LB:  data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
      LH:  data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      LW:  data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
      LD:  data_o = data_i;
      LBU: data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
      LHU: data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
      LWU: data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry slot feeding the regfile write port,
// the bypass network and the retired-instruction counter.
// Ports: clk/rst/flush/hold, MEM handshake + fields, rd_* write port,
// fwd_* bypass, instret_o.
module wb_stage #(
  parameter int XLEN      = 64,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 wb_hold_i,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [4:0]           mem_rd_addr_i,
  input  logic                 mem_rd_wen_i,
  input  logic                 mem_is_load_i,
  input  logic [2:0]           mem_funct3_i,
  input  logic [2:0]           mem_addr_lo_i,
  input  logic [XLEN-1:0]      mem_alu_result_i,
  input  logic [XLEN-1:0]      mem_load_data_i,
  output logic [4:0]           rd_addr_o,
  output logic                 rd_wen_o,
  output logic [XLEN-1:0]      result_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_addr_o,
  output logic [XLEN-1:0]      fwd_data_o,
  output logic [INSTRET_W-1:0] instret_o
);

  logic                 valid_q, valid_d;
  logic                 rd_wen_q;
  logic [4:0]           rd_addr_q;
  logic [XLEN-1:0]      result_q;
  logic [INSTRET_W-1:0] instret_q;
  logic [XLEN-1:0]      ld_fmt;
  logic [XLEN-1:0]      res_d;
  logic                 capture;
  logic                 retire;
  logic                 rd_nz;

  load_align u_align (
    .funct3_i  (mem_funct3_i),
    .addr_lo_i (mem_addr_lo_i),
    .data_i    (mem_load_data_i),
    .data_o    (ld_fmt)
  );

  assign mem_ready_o = !valid_q || !wb_hold_i;
  assign capture = mem_valid_i && mem_ready_o && !flush_i;
  assign retire  = valid_q && !wb_hold_i && !flush_i;
  assign rd_nz   = (rd_addr_q != 5'd0);
  assign res_d   = mem_is_load_i ? ld_fmt : mem_alu_result_i;

  // Flush beats capture, capture beats the retire-clear.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)      valid_d = 1'b0;
    else if (capture) valid_d = 1'b1;
    else if (retire)  valid_d = 1'b0;
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      rd_wen_q  <= 1'b0;
      rd_addr_q <= 5'd0;
      result_q  <= '0;
      instret_q <= INSTRET_W'(wb_stage_pkg::INSTRET_RST);
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        rd_wen_q  <= mem_rd_wen_i;
        rd_addr_q <= mem_rd_addr_i;
        result_q  <= res_d;
      end
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign result_o    = result_q;
  assign rd_wen_o    = retire && rd_wen_q && rd_nz;
  assign fwd_valid_o = valid_q && rd_wen_q && rd_nz;
  assign fwd_addr_o  = rd_addr_q;
  assign fwd_data_o  = result_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-format table, hand-written
// hold/flush/back-to-back sequences and a randomized model-checked run.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        flush_i, wb_hold_i, mem_valid_i, mem_ready_o;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_rd_wen_i, mem_is_load_i;
  logic [2:0]  mem_funct3_i, mem_addr_lo_i;
  logic [63:0] mem_alu_result_i, mem_load_data_i;
  logic [4:0]  rd_addr_o, fwd_addr_o;
  logic        rd_wen_o, fwd_valid_o;
  logic [63:0] result_o, fwd_data_o, instret_o;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk_sys_i        (clk),
    .rst_n_i          (rst_n_i),
    .flush_i          (flush_i),
    .wb_hold_i        (wb_hold_i),
    .mem_valid_i      (mem_valid_i),
    .mem_ready_o      (mem_ready_o),
    .mem_rd_addr_i    (mem_rd_addr_i),
    .mem_rd_wen_i     (mem_rd_wen_i),
    .mem_is_load_i    (mem_is_load_i),
    .mem_funct3_i     (mem_funct3_i),
    .mem_addr_lo_i    (mem_addr_lo_i),
    .mem_alu_result_i (mem_alu_result_i),
    .mem_load_data_i  (mem_load_data_i),
    .rd_addr_o        (rd_addr_o),
    .rd_wen_o         (rd_wen_o),
    .result_o         (result_o),
    .fwd_valid_o      (fwd_valid_o),
    .fwd_addr_o       (fwd_addr_o),
    .fwd_data_o       (fwd_data_o),
    .instret_o        (instret_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference slot contents
  logic        m_v, m_wen;
  logic [4:0]  m_rd;
  logic [63:0] m_res, m_cnt;

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  a;
    logic [63:0] exp;
  } ld_vec_t;

  localparam logic [63:0] RAW = 64'h8081_8283_F4F5_96A7;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Load formatting from the size/sign rules with plain arithmetic.
  function automatic logic [63:0] ref_load(logic [2:0] f3, logic [2:0] a,
                                           logic [63:0] raw);
    int sz, off;
    logic [63:0] mask, v;
    if (f3 == 3'b111) return 64'd0;
    sz   = 1 << f3[1:0];
    off  = (int'(a) / sz) * sz;
    v    = raw >> (8 * off);
    mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    v    = v & mask;
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                       input logic ld, input logic [2:0] f3,
                       input logic [2:0] a, input logic [63:0] alu,
                       input logic [63:0] raw, input logic hold,
                       input logic fl);
    mem_valid_i      = v;
    mem_rd_addr_i    = rd;
    mem_rd_wen_i     = wen;
    mem_is_load_i    = ld;
    mem_funct3_i     = f3;
    mem_addr_lo_i    = a;
    mem_alu_result_i = alu;
    mem_load_data_i  = raw;
    wb_hold_i        = hold;
    flush_i          = fl;
  endtask

  task automatic idle(input logic hold, input logic fl);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0, hold, fl);
  endtask

  task automatic model_reset();
    m_v = 0; m_wen = 0; m_rd = 0; m_res = 0; m_cnt = 0;
  endtask

  // Called ~1 time unit after a rising edge with inputs driven.
  // Compares every output to the model, advances the model, steps one edge.
  task automatic cycle();
    logic rdy, ret, cap, ewen, efwd;
    #2;
    rdy  = !m_v || !wb_hold_i;
    ret  = m_v && !wb_hold_i && !flush_i;
    ewen = ret && m_wen && (m_rd != 0);
    efwd = m_v && m_wen && (m_rd != 0);
    check("ready",    {63'd0, mem_ready_o}, {63'd0, rdy});
    check("rd_wen",   {63'd0, rd_wen_o},    {63'd0, ewen});
    check("fwd_valid",{63'd0, fwd_valid_o}, {63'd0, efwd});
    check("instret",  instret_o, m_cnt);
    if (m_v) begin
      check("rd_addr",  {59'd0, rd_addr_o},  {59'd0, m_rd});
      check("fwd_addr", {59'd0, fwd_addr_o}, {59'd0, m_rd});
      check("result",   result_o,   m_res);
      check("fwd_data", fwd_data_o, m_res);
    end
    cap = mem_valid_i && rdy && !flush_i;
    if (ret) m_cnt = m_cnt + 64'd1;
    if (flush_i) m_v = 0;
    else if (cap) begin
      m_v   = 1;
      m_rd  = mem_rd_addr_i;
      m_wen = mem_rd_wen_i;
      m_res = mem_is_load_i
            ? ref_load(mem_funct3_i, mem_addr_lo_i, mem_load_data_i)
            : mem_alu_result_i;
    end else if (ret) m_v = 0;
    @(posedge clk);
    #1;
  endtask

  ld_vec_t vecs[12];
  logic [63:0] base;
  int writes;
  logic [4:0] rds[4];

  initial begin
    vecs[0]  = '{3'b000, 3'd0, 64'hFFFF_FFFF_FFFF_FFA7};
    vecs[1]  = '{3'b100, 3'd1, 64'h0000_0000_0000_0096};
    vecs[2]  = '{3'b001, 3'd2, 64'hFFFF_FFFF_FFFF_F4F5};
    vecs[3]  = '{3'b110, 3'd4, 64'h0000_0000_8081_8283};
    vecs[4]  = '{3'b011, 3'd5, 64'h8081_8283_F4F5_96A7};
    vecs[5]  = '{3'b010, 3'd4, 64'hFFFF_FFFF_8081_8283};
    vecs[6]  = '{3'b101, 3'd6, 64'h0000_0000_0000_8081};
    vecs[7]  = '{3'b001, 3'd3, 64'hFFFF_FFFF_FFFF_F4F5};
    vecs[8]  = '{3'b000, 3'd5, 64'hFFFF_FFFF_FFFF_FF82};
    vecs[9]  = '{3'b010, 3'd1, 64'hFFFF_FFFF_F4F5_96A7};
    vecs[10] = '{3'b111, 3'd0, 64'h0000_0000_0000_0000};
    vecs[11] = '{3'b100, 3'd7, 64'h0000_0000_0000_0080};

    rst_n_i = 1'b0;
    idle(1'b0, 1'b0);
    model_reset();
    #2;
    check("rst_wen",   {63'd0, rd_wen_o},    64'd0);
    check("rst_ready", {63'd0, mem_ready_o}, 64'd1);
    check("rst_fwd",   {63'd0, fwd_valid_o}, 64'd0);
    check("rst_inst",  instret_o, 64'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n_i = 1'b1;

    // ALU retire, x5 <- 0x1234
    drive(1, 5'd5, 1, 0, 3'd0, 3'd0, 64'h1234, 64'd0, 0, 0);
    cycle();
    idle(0, 0);
    #1;
    check("alu_wen",  {63'd0, rd_wen_o}, 64'd1);
    check("alu_addr", {59'd0, rd_addr_o}, 64'd5);
    check("alu_res",  result_o, 64'h1234);
    check("alu_inst0", instret_o, 64'd0);
    cycle();
    check("alu_inst1", instret_o, 64'd1);

    // Load formatting table
    for (int i = 0; i < 12; i++) begin
      drive(1, 5'd10, 1, 1, vecs[i].f3, vecs[i].a, 64'hDEAD, RAW, 0, 0);
      cycle();
      idle(0, 0);
      #1;
      check($sformatf("load%0d", i), result_o, vecs[i].exp);
      cycle();
    end

    // Hold for three cycles, then release
    drive(1, 5'd9, 1, 0, 3'd0, 3'd0, 64'hABCD, 64'd0, 0, 0);
    cycle();
    base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd11, 1, 0, 3'd0, 3'd0, 64'h55, 64'd0, 1, 0);
      #1;
      check("hold_ready", {63'd0, mem_ready_o}, 64'd0);
      check("hold_wen",   {63'd0, rd_wen_o},    64'd0);
      check("hold_fwd",   {63'd0, fwd_valid_o}, 64'd1);
      check("hold_inst",  instret_o, base);
      cycle();
    end
    idle(0, 0);
    #1;
    check("rel_wen", {63'd0, rd_wen_o}, 64'd1);
    check("rel_res", result_o, 64'hABCD);
    cycle();
    check("rel_inst", instret_o, base + 64'd1);

    // Flush a held entry while MEM also presents one
    drive(1, 5'd7, 1, 0, 3'd0, 3'd0, 64'h77, 64'd0, 0, 0);
    cycle();
    base = m_cnt;
    idle(1, 0);
    cycle();
    drive(1, 5'd8, 1, 0, 3'd0, 3'd0, 64'h88, 64'd0, 1, 1);
    #1;
    check("fl_wen", {63'd0, rd_wen_o}, 64'd0);
    cycle();
    idle(0, 0);
    #1;
    check("fl_fwd",  {63'd0, fwd_valid_o}, 64'd0);
    check("fl_wen2", {63'd0, rd_wen_o},    64'd0);
    cycle();
    check("fl_inst", instret_o, base);

    // Back-to-back with an x0 destination
    rds[0] = 5'd1; rds[1] = 5'd0; rds[2] = 5'd2; rds[3] = 5'd3;
    base = m_cnt;
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, rds[i], 1, 0, 3'd0, 3'd0, 64'(100 + i), 64'd0, 0, 0);
      #1;
      if (rd_wen_o) writes++;
      if (i == 2) check("x0_fwd", {63'd0, fwd_valid_o}, 64'd0);
      cycle();
    end
    idle(0, 0);
    #1;
    if (rd_wen_o) writes++;
    cycle();
    check("b2b_writes", 64'(writes), 64'd3);
    check("b2b_inst", instret_o, base + 64'd4);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 10) < 7,
            (($urandom % 8) == 0) ? 5'd0 : 5'($urandom),
            ($urandom % 4) != 0,
            $urandom % 2 == 1,
            3'($urandom), 3'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom % 4) == 0,
            ($urandom % 10) == 0);
      cycle();
    end

    // Asynchronous reset in mid-cycle with a live slot
    drive(1, 5'd4, 1, 0, 3'd0, 3'd0, 64'h44, 64'd0, 0, 0);
    cycle();
    idle(1, 0);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_wen",   {63'd0, rd_wen_o},    64'd0);
    check("arst_ready", {63'd0, mem_ready_o}, 64'd1);
    check("arst_fwd",   {63'd0, fwd_valid_o}, 64'd0);
    check("arst_inst",  instret_o, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n_i = 1'b1;
    idle(0, 0);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
